// File: rtl/orao_tape_rec.sv
// rtl/orao_tape_rec.sv - tape-save decoder: toggle intervals to bytes written into the tape buffer
module orao_tape_rec #(
    parameter int                CNT_W       = 12,
    parameter logic [CNT_W-1:0]  HALF_THRESH = 12'd400,
    parameter logic [CNT_W-1:0]  TIMEOUT     = 12'd4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] addr,
    input  logic        rec_clear,
    output logic [15:0] tape_wr_addr,
    output logic [7:0]  tape_wr_data,
    output logic        tape_wr,
    input  logic        tape_wr_ack,
    output logic        rec_active,
    output logic        rec_err,
    output logic        rec_overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             h1;

    logic             ev;
    logic             is_long;
    logic             timed_out;
    logic             shift_en;
    logic             err_set;
    logic             h1_load;
    logic             bits_clr;
    logic             byte_done;
    logic [7:0]       byte_val;
    logic             retire;
    logic             busy;
    logic             unused_addr;

    // Any access in the tape flip-flop window flips the output, so every such cycle is a toggle.
    assign ev          = ce && (addr[15:11] == 5'b10001);
    assign unused_addr = ^addr[10:0];
    assign is_long     = (cnt > HALF_THRESH);
    assign timed_out   = (cnt == TIMEOUT);
    assign rec_active  = (state != IDLE);
    assign byte_done   = shift_en && (bit_cnt == 3'd7);
    assign byte_val    = {is_long, shreg[7:1]};
    // Ack retires the old write before a same-cycle byte completion looks at tape_wr.
    assign retire      = tape_wr && tape_wr_ack;
    assign busy        = tape_wr && !tape_wr_ack;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (rec_clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-cycle decode strobes; an event always beats a timeout.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        err_set    = 1'b0;
        h1_load    = 1'b0;
        bits_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (ev) begin
                    next_state = FIRST;
                end
            end
            FIRST: begin
                if (ev) begin
                    h1_load    = 1'b1;
                    next_state = SECOND;
                end else if (timed_out) begin
                    bits_clr   = 1'b1;
                    next_state = IDLE;
                end
            end
            SECOND: begin
                if (ev) begin
                    if (h1 == is_long) begin
                        shift_en   = 1'b1;
                        next_state = FIRST;
                    end else begin
                        err_set    = 1'b1;
                        h1_load    = 1'b1;
                    end
                end else if (timed_out) begin
                    bits_clr   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Interval counter, bit assembly, sticky flags and the buffer write handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            h1           <= 1'b0;
            tape_wr      <= 1'b0;
            tape_wr_addr <= 16'd0;
            tape_wr_data <= 8'd0;
            rec_err      <= 1'b0;
            rec_overrun  <= 1'b0;
        end else if (rec_clear) begin
            cnt          <= '0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            tape_wr      <= 1'b0;
            tape_wr_addr <= 16'd0;
            rec_err      <= 1'b0;
            rec_overrun  <= 1'b0;
        end else begin
            if (ev) begin
                cnt <= '0;
            end else if (ce && !timed_out) begin
                cnt <= cnt + 1'b1;
            end

            if (h1_load) begin
                h1 <= is_long;
            end
            if (err_set) begin
                rec_err <= 1'b1;
            end

            if (bits_clr) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                shreg   <= byte_val;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (retire) begin
                tape_wr      <= 1'b0;
                tape_wr_addr <= tape_wr_addr + 16'd1;
            end
            if (byte_done) begin
                if (busy) begin
                    rec_overrun <= 1'b1;
                end else begin
                    tape_wr      <= 1'b1;
                    tape_wr_data <= byte_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_orao_tape_rec.sv
// tb/tb_orao_tape_rec.sv - directed bench for the tape-save decoder
module tb_orao_tape_rec;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [15:0] addr;
    logic        rec_clear;
    logic [15:0] tape_wr_addr;
    logic [7:0]  tape_wr_data;
    logic        tape_wr;
    logic        tape_wr_ack;
    logic        rec_active;
    logic        rec_err;
    logic        rec_overrun;

    int checks;
    int fails;

    logic [15:0] log_addr [0:15];
    logic [7:0]  log_data [0:15];
    int          log_n;
    logic        prev_wr;
    logic        ack_en;
    int          ack_delay;
    int          wait_cnt;

    orao_tape_rec dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .addr         (addr),
        .rec_clear    (rec_clear),
        .tape_wr_addr (tape_wr_addr),
        .tape_wr_data (tape_wr_data),
        .tape_wr      (tape_wr),
        .tape_wr_ack  (tape_wr_ack),
        .rec_active   (rec_active),
        .rec_err      (rec_err),
        .rec_overrun  (rec_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: logs each new request and answers with an ack after ack_delay cycles.
    initial begin
        tape_wr_ack = 1'b0;
        prev_wr     = 1'b0;
        wait_cnt    = 0;
        log_n       = 0;
        forever begin
            @(negedge clk);
            if (tape_wr && (!prev_wr || tape_wr_ack)) begin
                if (log_n < 16) begin
                    log_addr[log_n] = tape_wr_addr;
                    log_data[log_n] = tape_wr_data;
                end
                log_n++;
            end
            prev_wr = tape_wr;
            if (tape_wr_ack) begin
                tape_wr_ack = 1'b0;
            end else if (tape_wr && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    tape_wr_ack = 1'b1;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic ev_now(input logic [15:0] a);
        addr = a;
        @(negedge clk);
        addr = 16'h0000;
    endtask

    task automatic pulse_after(input int n);
        repeat (n - 1) @(negedge clk);
        ev_now(16'h8A5C);
    endtask

    task automatic send_bit(input logic b);
        pulse_after(b ? 600 : 200);
        pulse_after(b ? 600 : 200);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_clear();
        rec_clear = 1'b1;
        @(negedge clk);
        rec_clear = 1'b0;
        log_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; addr = 16'h0000; rec_clear = 1'b0;
        ack_en = 1'b1; ack_delay = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (tape_wr !== 1'b0) begin $display("FAIL reset_wr got %b want 0", tape_wr); fails++; end
        checks++; if (tape_wr_addr !== 16'h0000) begin $display("FAIL reset_addr got %h want 0000", tape_wr_addr); fails++; end
        checks++; if (tape_wr_data !== 8'h00) begin $display("FAIL reset_data got %h want 00", tape_wr_data); fails++; end
        checks++; if ({rec_active, rec_err, rec_overrun} !== 3'b000) begin $display("FAIL reset_flags got %b want 000", {rec_active, rec_err, rec_overrun}); fails++; end
    endtask

    task automatic test_byte_a5();
        do_clear();
        ack_en = 1'b1; ack_delay = 3;
        ev_now(16'h8800);
        checks++; if (rec_active !== 1'b1) begin $display("FAIL a5_active got %b want 1", rec_active); fails++; end
        send_byte(8'hA5);
        checks++; if (tape_wr !== 1'b1) begin $display("FAIL a5_latency got %b want 1", tape_wr); fails++; end
        checks++; if (tape_wr_data !== 8'hA5) begin $display("FAIL a5_data got %h want a5", tape_wr_data); fails++; end
        checks++; if (tape_wr_addr !== 16'h0000) begin $display("FAIL a5_addr got %h want 0000", tape_wr_addr); fails++; end
        repeat (10) @(negedge clk);
        checks++; if (tape_wr_addr !== 16'h0001) begin $display("FAIL a5_addr_after got %h want 0001", tape_wr_addr); fails++; end
        checks++; if (tape_wr !== 1'b0) begin $display("FAIL a5_wr_after got %b want 0", tape_wr); fails++; end
        checks++; if (rec_err !== 1'b0) begin $display("FAIL a5_err got %b want 0", rec_err); fails++; end
        checks++; if (log_n !== 1) begin $display("FAIL a5_nwrites got %0d want 1", log_n); fails++; end
    endtask

    task automatic test_back_to_back();
        do_clear();
        ack_en = 1'b1; ack_delay = 0;
        ev_now(16'h8FFF);
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (5) @(negedge clk);
        checks++; if (log_n !== 2) begin $display("FAIL b2b_nwrites got %0d want 2", log_n); fails++; end
        checks++; if ({log_addr[0], log_data[0]} !== 24'h0000_00) begin $display("FAIL b2b_first got %h want 000000", {log_addr[0], log_data[0]}); fails++; end
        checks++; if ({log_addr[1], log_data[1]} !== 24'h0001_FF) begin $display("FAIL b2b_second got %h want 0001ff", {log_addr[1], log_data[1]}); fails++; end
        checks++; if (tape_wr_addr !== 16'h0002) begin $display("FAIL b2b_addr got %h want 0002", tape_wr_addr); fails++; end
    endtask

    task automatic test_mismatch();
        do_clear();
        ack_en = 1'b1; ack_delay = 0;
        ev_now(16'h8800);
        pulse_after(600);
        pulse_after(200);
        checks++; if (rec_err !== 1'b1) begin $display("FAIL mm_err got %b want 1", rec_err); fails++; end
        pulse_after(200);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        repeat (5) @(negedge clk);
        checks++; if (log_n !== 1) begin $display("FAIL mm_nwrites got %0d want 1", log_n); fails++; end
        checks++; if (log_data[0] !== 8'h00) begin $display("FAIL mm_data got %h want 00", log_data[0]); fails++; end
        checks++; if (rec_err !== 1'b1) begin $display("FAIL mm_sticky got %b want 1", rec_err); fails++; end
    endtask

    task automatic test_timeout();
        do_clear();
        ack_en = 1'b1; ack_delay = 0;
        ev_now(16'h8800);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        repeat (4000) @(negedge clk);
        checks++; if (rec_active !== 1'b1) begin $display("FAIL to_before got %b want 1", rec_active); fails++; end
        @(negedge clk);
        checks++; if (rec_active !== 1'b0) begin $display("FAIL to_after got %b want 0", rec_active); fails++; end
        ev_now(16'h8800);
        send_byte(8'h3C);
        repeat (5) @(negedge clk);
        checks++; if (log_n !== 1) begin $display("FAIL to_nwrites got %0d want 1", log_n); fails++; end
        checks++; if ({log_addr[0], log_data[0]} !== 24'h0000_3C) begin $display("FAIL to_write got %h want 00003c", {log_addr[0], log_data[0]}); fails++; end
    endtask

    task automatic test_overrun();
        do_clear();
        ack_en = 1'b0;
        ev_now(16'h8800);
        send_byte(8'h5A);
        send_byte(8'h01);
        checks++; if (tape_wr !== 1'b1) begin $display("FAIL ovr_pending got %b want 1", tape_wr); fails++; end
        checks++; if (tape_wr_data !== 8'h5A) begin $display("FAIL ovr_data got %h want 5a", tape_wr_data); fails++; end
        checks++; if (rec_overrun !== 1'b1) begin $display("FAIL ovr_flag got %b want 1", rec_overrun); fails++; end
        ack_en = 1'b1; ack_delay = 0;
        repeat (5) @(negedge clk);
        checks++; if (tape_wr_addr !== 16'h0001) begin $display("FAIL ovr_addr got %h want 0001", tape_wr_addr); fails++; end
        checks++; if (tape_wr !== 1'b0) begin $display("FAIL ovr_wr got %b want 0", tape_wr); fails++; end
        checks++; if (log_n !== 1) begin $display("FAIL ovr_nwrites got %0d want 1", log_n); fails++; end
    endtask

    task automatic test_clear();
        do_clear();
        ack_en = 1'b0;
        ev_now(16'h8800);
        pulse_after(600);
        pulse_after(200);
        pulse_after(200);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_byte(8'h00);
        checks++; if ({tape_wr, rec_err, rec_overrun} !== 3'b111) begin $display("FAIL clr_pre got %b want 111", {tape_wr, rec_err, rec_overrun}); fails++; end
        rec_clear = 1'b1;
        @(negedge clk);
        rec_clear = 1'b0;
        checks++; if (tape_wr !== 1'b0) begin $display("FAIL clr_wr got %b want 0", tape_wr); fails++; end
        checks++; if (tape_wr_addr !== 16'h0000) begin $display("FAIL clr_addr got %h want 0000", tape_wr_addr); fails++; end
        checks++; if ({rec_active, rec_err, rec_overrun} !== 3'b000) begin $display("FAIL clr_flags got %b want 000", {rec_active, rec_err, rec_overrun}); fails++; end
    endtask

    task automatic test_async_reset();
        do_clear();
        ack_en = 1'b1; ack_delay = 0;
        ev_now(16'h8800);
        send_byte(8'h01);
        repeat (3) @(negedge clk);
        ack_en = 1'b0;
        send_byte(8'h80);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        checks++; if ({tape_wr, tape_wr_addr, tape_wr_data} !== 25'h1_0001_80) begin $display("FAIL ar_pre got %h want 1000180", {tape_wr, tape_wr_addr, tape_wr_data}); fails++; end
        #2 reset = 1'b1;
        #1;
        checks++; if (tape_wr !== 1'b0) begin $display("FAIL ar_wr got %b want 0", tape_wr); fails++; end
        checks++; if (tape_wr_addr !== 16'h0000) begin $display("FAIL ar_addr got %h want 0000", tape_wr_addr); fails++; end
        checks++; if (tape_wr_data !== 8'h00) begin $display("FAIL ar_data got %h want 00", tape_wr_data); fails++; end
        checks++; if ({rec_active, rec_err, rec_overrun} !== 3'b000) begin $display("FAIL ar_flags got %b want 000", {rec_active, rec_err, rec_overrun}); fails++; end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_byte_a5();
        test_back_to_back();
        test_mismatch();
        test_timeout();
        test_overrun();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
